// File: rtl/raven_pe_pkg.sv
// Shared types and constants for the PE fan-out / reduction trees.
package raven_pe_pkg;

  typedef enum logic [1:0] {
    L0 = 2'd0,
    L1 = 2'd1,
    L2 = 2'd2,
    L3 = 2'd3
  } fanout_level_e;

  localparam int unsigned LANES      = 64;
  localparam int unsigned BEAT_LANES = 4;

  function automatic logic [4:0] beats_for_level(input fanout_level_e level);
    case (level)
      L0:      return 5'd16;
      L1:      return 5'd4;
      default: return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/fanout_tree_bank.sv
// One 64-lane vector bank with level-dependent placement of 4-word beats.
module fanout_tree_bank
  import raven_pe_pkg::*;
#(
  parameter int unsigned ACC_BW = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_en,
  input  logic                                 first,
  input  fanout_level_e                        wr_level,
  input  logic [3:0]                           beat,
  input  logic [BEAT_LANES-1:0][ACC_BW-1:0]    data,
  output logic [LANES-1:0][ACC_BW-1:0]         lanes,
  output fanout_level_e                        level
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes <= '0;
      level <= L0;
    end else if (wr_en) begin
      if (first) level <= wr_level;
      // Lane index bits select the source word: L0 lane=4b+k, L1 lane/4=4b+k, L2 lane/16=k.
      for (int unsigned i = 0; i < LANES; i++) begin
        case (wr_level)
          L0: if (i[5:2] == beat)      lanes[i] <= data[i[1:0]];
          L1: if (i[5:4] == beat[1:0]) lanes[i] <= data[i[3:2]];
          L2: lanes[i] <= data[i[5:4]];
          default: lanes[i] <= data[0];
        endcase
      end
    end
  end

endmodule

// File: rtl/fanout_tree_64.sv
// Ping-pong beat assembler: 4-word beats in, replicated 64-lane vectors out.
module fanout_tree_64
  import raven_pe_pkg::*;
#(
  parameter int unsigned ACC_BW = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [1:0]                         cfg_level,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [BEAT_LANES-1:0][ACC_BW-1:0]  in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES-1:0][ACC_BW-1:0]       out,
  output logic [1:0]                         out_level
);

  logic [1:0]                          full;
  logic [1:0]                          full_nxt;
  logic                                wr_bank;
  logic                                rd_bank;
  logic [3:0]                          beat_cnt;
  logic [1:0][LANES-1:0][ACC_BW-1:0]   bank_lanes;
  fanout_level_e                       bank_level [2];
  fanout_level_e                       wr_level;
  logic                                accept;
  logic                                drain;
  logic                                last;
  logic                                first;

  // Beat 0 takes the live cfg_level; later beats use the level latched in the bank.
  assign first    = (beat_cnt == '0);
  assign wr_level = first ? fanout_level_e'(cfg_level) : bank_level[wr_bank];
  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[rd_bank];
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid & out_ready & ~flush;
  assign last      = ({1'b0, beat_cnt} == (beats_for_level(wr_level) - 5'd1));

  fanout_tree_bank #(.ACC_BW(ACC_BW)) u_bank0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept & ~wr_bank),
    .first    (first),
    .wr_level (wr_level),
    .beat     (beat_cnt),
    .data     (in_data),
    .lanes    (bank_lanes[0]),
    .level    (bank_level[0])
  );

  fanout_tree_bank #(.ACC_BW(ACC_BW)) u_bank1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept & wr_bank),
    .first    (first),
    .wr_level (wr_level),
    .beat     (beat_cnt),
    .data     (in_data),
    .lanes    (bank_lanes[1]),
    .level    (bank_level[1])
  );

  // Fill completes only into an empty bank and drain only from a full one, so they never collide.
  always_comb begin
    full_nxt = full;
    if (accept && last) full_nxt[wr_bank] = 1'b1;
    if (drain)          full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      beat_cnt <= '0;
    end else if (flush) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        if (last) begin
          wr_bank  <= ~wr_bank;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 4'd1;
        end
      end
      if (drain) rd_bank <= ~rd_bank;
    end
  end

  assign out       = out_valid ? bank_lanes[rd_bank] : '0;
  assign out_level = bank_level[rd_bank];

endmodule

// File: tb/tb_fanout_tree_64.sv
// Directed self-checking bench for fanout_tree_64.
module tb_fanout_tree_64;

  localparam int unsigned BW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic [1:0]           cfg_level;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0][BW-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [63:0][BW-1:0]  out_vec;
  logic [1:0]           out_level;

  logic [63:0][BW-1:0]  exp_vec;
  int                   checks = 0;
  int                   errors = 0;
  int                   lane;

  always #5 clk = ~clk;

  fanout_tree_64 #(.ACC_BW(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cfg_level (cfg_level),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_vec),
    .out_level (out_level)
  );

  function automatic int first_diff(input logic [63:0][BW-1:0] a, input logic [63:0][BW-1:0] b);
    for (int i = 0; i < 64; i++) if (a[i] !== b[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [3:0][BW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_level = 2'd0; in_data = '0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_vec !== '0) begin errors++; lane = first_diff(out_vec, '0); $display("FAIL reset_out lane %0d: got %h expected 0", lane, out_vec[lane]); end
    checks++; if (out_level !== 2'd0) begin errors++; $display("FAIL reset_out_level: got %0d expected 0", out_level); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_vec !== '0) begin errors++; lane = first_diff(out_vec, '0); $display("FAIL idle_out lane %0d: got %h expected 0", lane, out_vec[lane]); end
  endtask

  task automatic test_l0();
    logic [3:0][BW-1:0] d;
    cfg_level = 2'd0; out_ready = 1'b0;
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 4; k++) d[k] = 32'(4 * b + k);
      send_beat(d);
      if (b == 14) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL l0_early_valid: got %b expected 0", out_valid); end
      end
    end
    for (int i = 0; i < 64; i++) exp_vec[i] = 32'(i);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL l0_latency: got %b expected 1", out_valid); end
    checks++; if (out_level !== 2'd0) begin errors++; $display("FAIL l0_level: got %0d expected 0", out_level); end
    checks++; if (out_vec !== exp_vec) begin errors++; lane = first_diff(out_vec, exp_vec); $display("FAIL l0_vector lane %0d: got %h expected %h", lane, out_vec[lane], exp_vec[lane]); end
    tick();
    checks++; if (out_vec !== exp_vec) begin errors++; lane = first_diff(out_vec, exp_vec); $display("FAIL l0_stall lane %0d: got %h expected %h", lane, out_vec[lane], exp_vec[lane]); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL l0_drain_valid: got %b expected 0", out_valid); end
    checks++; if (out_vec !== '0) begin errors++; lane = first_diff(out_vec, '0); $display("FAIL l0_gated lane %0d: got %h expected 0", lane, out_vec[lane]); end
  endtask

  task automatic test_l1();
    logic [3:0][BW-1:0] d;
    cfg_level = 2'd1; out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) d[k] = 32'(16 * b + k + 1);
      send_beat(d);
    end
    for (int i = 0; i < 64; i++) exp_vec[i] = 32'(16 * (i / 16) + (i / 4) % 4 + 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL l1_valid: got %b expected 1", out_valid); end
    checks++; if (out_level !== 2'd1) begin errors++; $display("FAIL l1_level: got %0d expected 1", out_level); end
    checks++; if (out_vec !== exp_vec) begin errors++; lane = first_diff(out_vec, exp_vec); $display("FAIL l1_vector lane %0d: got %h expected %h", lane, out_vec[lane], exp_vec[lane]); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0][BW-1:0] exp_b;
    cfg_level = 2'd3; out_ready = 1'b0;
    send_beat({32'h11, 32'h22, 32'h33, 32'hA5});
    send_beat({32'h44, 32'h55, 32'h66, 32'h5A});
    for (int i = 0; i < 64; i++) begin exp_vec[i] = 32'hA5; exp_b[i] = 32'h5A; end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_level !== 2'd3) begin errors++; $display("FAIL b2b_level: got %0d expected 3", out_level); end
    in_valid = 1'b1; in_data = {4{32'hFF}};
    repeat (2) tick();
    in_valid = 1'b0; in_data = '0;
    checks++; if (out_vec !== exp_vec) begin errors++; lane = first_diff(out_vec, exp_vec); $display("FAIL b2b_held lane %0d: got %h expected %h", lane, out_vec[lane], exp_vec[lane]); end
    out_ready = 1'b1; tick();
    checks++; if (out_vec !== exp_b) begin errors++; lane = first_diff(out_vec, exp_b); $display("FAIL b2b_second lane %0d: got %h expected %h", lane, out_vec[lane], exp_b[lane]); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_back: got %b expected 1", in_ready); end
    tick(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_l2_stream();
    logic [3:0][BW-1:0] d;
    cfg_level = 2'd2; out_ready = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      for (int k = 0; k < 4; k++) d[k] = 32'(256 * n + k);
      send_beat(d);
      for (int i = 0; i < 64; i++) exp_vec[i] = 32'(256 * n + i / 16);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL l2_stream_valid beat %0d: got %b expected 1", n, out_valid); end
      checks++; if (out_vec !== exp_vec) begin errors++; lane = first_diff(out_vec, exp_vec); $display("FAIL l2_stream beat %0d lane %0d: got %h expected %h", n, lane, out_vec[lane], exp_vec[lane]); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL l2_stream_in_ready beat %0d: got %b expected 1", n, in_ready); end
    end
    tick(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL l2_stream_end: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    logic [3:0][BW-1:0] d;
    cfg_level = 2'd0; out_ready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 4; k++) d[k] = 32'(500 + 4 * b + k);
      send_beat(d);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = {4{32'hDEAD}};
    tick();
    flush = 1'b0; in_valid = 1'b0; in_data = '0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    cfg_level = 2'd2;
    send_beat({32'd4, 32'd3, 32'd2, 32'd1});
    for (int i = 0; i < 64; i++) exp_vec[i] = 32'(i / 16 + 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_l2_valid: got %b expected 1", out_valid); end
    checks++; if (out_level !== 2'd2) begin errors++; $display("FAIL flush_l2_level: got %0d expected 2", out_level); end
    checks++; if (out_vec !== exp_vec) begin errors++; lane = first_diff(out_vec, exp_vec); $display("FAIL flush_l2_vector lane %0d: got %h expected %h", lane, out_vec[lane], exp_vec[lane]); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_level_change();
    logic [3:0][BW-1:0] d;
    cfg_level = 2'd0; out_ready = 1'b0;
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 4; k++) d[k] = 32'(200 + 4 * b + k);
      send_beat(d);
      cfg_level = 2'd3;
      if (b == 3) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lvlchg_early_valid: got %b expected 0", out_valid); end
      end
    end
    for (int i = 0; i < 64; i++) exp_vec[i] = 32'(200 + i);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lvlchg_valid: got %b expected 1", out_valid); end
    checks++; if (out_level !== 2'd0) begin errors++; $display("FAIL lvlchg_level: got %0d expected 0", out_level); end
    checks++; if (out_vec !== exp_vec) begin errors++; lane = first_diff(out_vec, exp_vec); $display("FAIL lvlchg_vector lane %0d: got %h expected %h", lane, out_vec[lane], exp_vec[lane]); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    cfg_level = 2'd0; out_ready = 1'b0;
    send_beat({4{32'h77}});
    send_beat({4{32'h78}});
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_vec !== '0) begin errors++; lane = first_diff(out_vec, '0); $display("FAIL areset_out lane %0d: got %h expected 0", lane, out_vec[lane]); end
    tick();
    rst_n = 1'b1;
    tick();
    cfg_level = 2'd2;
    send_beat({32'd8, 32'd7, 32'd6, 32'd5});
    for (int i = 0; i < 64; i++) exp_vec[i] = 32'(i / 16 + 5);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_l2_valid: got %b expected 1", out_valid); end
    checks++; if (out_vec !== exp_vec) begin errors++; lane = first_diff(out_vec, exp_vec); $display("FAIL areset_l2_vector lane %0d: got %h expected %h", lane, out_vec[lane], exp_vec[lane]); end
  endtask

  initial begin
    test_reset();
    test_l0();
    test_l1();
    test_back_to_back();
    test_l2_stream();
    test_flush();
    test_level_change();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
